// File: rtl/serialtopar_sync.sv
// Serial-to-parallel deserializer with comma-based word alignment.
// Hunts for COMMA, confirms it on LOCK_CNT word boundaries, then delivers words until misaligned commas force a re-search.
module serialtopar_sync #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] COMMA      = WIDTH'(8'hBC),
  parameter int               LOCK_CNT   = 4,
  parameter int               UNLOCK_CNT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             word_stb,
  output logic             locked
);

  localparam int BW = $clog2(WIDTH);

  typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;

  state_t           state_q, state_d;
  // Only the WIDTH-1 newest bits need keeping; the oldest bit of shift falls out next cycle.
  logic [WIDTH-2:0] shreg_q, shreg_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [3:0]       comma_cnt_q, comma_cnt_d;
  logic [3:0]       miss_cnt_q, miss_cnt_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             valid_out_q, valid_out_d;
  logic             word_stb_q, word_stb_d;
  logic             locked_q, locked_d;

  logic [WIDTH-1:0] shift;
  logic             boundary;
  logic             is_comma;
  logic [3:0]       comma_inc;
  logic [3:0]       miss_inc;

  always_comb begin
    shift     = {data_in, shreg_q};
    boundary  = (bit_cnt_q == BW'(WIDTH - 1));
    is_comma  = (shift == COMMA);
    comma_inc = (comma_cnt_q == 4'hF) ? comma_cnt_q : comma_cnt_q + 4'd1;
    miss_inc  = (miss_cnt_q  == 4'hF) ? miss_cnt_q  : miss_cnt_q  + 4'd1;

    state_d     = state_q;
    shreg_d     = shift[WIDTH-1:1];
    bit_cnt_d   = boundary ? '0 : bit_cnt_q + BW'(1);
    comma_cnt_d = comma_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    data_out_d  = data_out_q;
    valid_out_d = valid_out_q;
    word_stb_d  = 1'b0;

    // Boundary capture uses the pre-transition state, so an ALIGN->LOCKED word stays invalid.
    if (state_q != SEARCH && boundary) begin
      data_out_d  = shift;
      word_stb_d  = 1'b1;
      valid_out_d = (state_q == LOCKED) && !is_comma;
    end

    case (state_q)
      SEARCH: begin
        valid_out_d = 1'b0;
        if (is_comma) begin
          bit_cnt_d   = '0;
          comma_cnt_d = 4'd1;
          miss_cnt_d  = '0;
          state_d     = (LOCK_CNT == 1) ? LOCKED : ALIGN;
        end
      end
      ALIGN: begin
        if (boundary) begin
          if (is_comma) begin
            comma_cnt_d = comma_inc;
            if (comma_inc >= 4'(LOCK_CNT)) begin
              state_d    = LOCKED;
              miss_cnt_d = '0;
            end
          end else begin
            state_d     = SEARCH;
            comma_cnt_d = '0;
          end
        end
      end
      LOCKED: begin
        if (is_comma && boundary) begin
          miss_cnt_d = '0;
        end else if (is_comma) begin
          miss_cnt_d = miss_inc;
          if (miss_inc >= 4'(UNLOCK_CNT)) begin
            state_d     = SEARCH;
            miss_cnt_d  = '0;
            comma_cnt_d = '0;
            valid_out_d = 1'b0;
            word_stb_d  = 1'b0;
          end
        end
      end
      default: state_d = SEARCH;
    endcase

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SEARCH;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      comma_cnt_q <= '0;
      miss_cnt_q  <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      word_stb_q  <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      comma_cnt_q <= comma_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      word_stb_q  <= word_stb_d;
      locked_q    <= locked_d;
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign word_stb  = word_stb_q;
  assign locked    = locked_q;

endmodule
